// File: rtl/axi_burst_pkg.sv
// Shared encodings, FSM state codes and the burst data pattern rule
// used by the AXI burst write/read-compare engine.
package axi_burst_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef logic [2:0] axi_state_t;

  localparam axi_state_t ST_IDLE = 3'd0;
  localparam axi_state_t ST_AW   = 3'd1;
  localparam axi_state_t ST_WDLY = 3'd2;
  localparam axi_state_t ST_W    = 3'd3;
  localparam axi_state_t ST_B    = 3'd4;
  localparam axi_state_t ST_AR   = 3'd5;
  localparam axi_state_t ST_R    = 3'd6;
  localparam axi_state_t ST_DONE = 3'd7;

  // 32-bit lane value: seed + beat*lanes_per_beat + lane, wrapping mod 2^32.
  function automatic logic [31:0] pattern_lane(
    input logic [31:0] seed,
    input logic [31:0] beat,
    input logic [31:0] lanes,
    input logic [31:0] lane
  );
    return seed + beat * lanes + lane;
  endfunction

endpackage

// File: rtl/axi_burst_tester_pattern_gen.sv
// Maps (seed, beat index) to a full data word, one 32-bit lane per slice,
// lane 0 in the least significant bits.
module axi_burst_pattern_gen
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BEAT_W     = 6
) (
  input  logic [31:0]           seed,
  input  logic [BEAT_W-1:0]     beat,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int LANES = DATA_WIDTH / 32;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign data[gi*32 +: 32] = pattern_lane(seed, 32'(beat), 32'(LANES), 32'(gi));
    end
  endgenerate

endmodule

// File: rtl/axi_burst_tester.sv
// Single INCR burst write of a generated pattern, or burst read compared
// beat by beat against the same pattern, on an AXI4 memory master port.
module axi_burst_tester
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 4,
  parameter int ID_WIDTH    = 6,
  parameter int DELAY_WIDTH = 8,
  parameter int TX_ID       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_write,
  input  logic                    start_read,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    burst_len,
  input  logic [31:0]             seed,
  input  logic [DELAY_WIDTH-1:0]  cmd_delay,
  output logic                    busy,
  output logic                    done,
  output logic                    addr_error,
  output logic                    resp_error,
  output logic [15:0]             error_count,
  output logic [DATA_WIDTH-1:0]   read_data,

  output logic                    m_memory_awvalid,
  input  logic                    m_memory_awready,
  output logic [ADDR_WIDTH-1:0]   m_memory_awaddr,
  output logic [LEN_WIDTH-1:0]    m_memory_awlen,
  output logic [ID_WIDTH-1:0]     m_memory_awid,
  output logic [2:0]              m_memory_awsize,
  output logic [1:0]              m_memory_awburst,
  output logic                    m_memory_awlock,
  output logic [3:0]              m_memory_awcache,
  output logic [2:0]              m_memory_awprot,
  output logic [3:0]              m_memory_awqos,

  output logic                    m_memory_wvalid,
  input  logic                    m_memory_wready,
  output logic [DATA_WIDTH-1:0]   m_memory_wdata,
  output logic [DATA_WIDTH/8-1:0] m_memory_wstrb,
  output logic                    m_memory_wlast,
  output logic [ID_WIDTH-1:0]     m_memory_wid,

  input  logic                    m_memory_bvalid,
  output logic                    m_memory_bready,
  input  logic [1:0]              m_memory_bresp,
  input  logic [ID_WIDTH-1:0]     m_memory_bid,

  output logic                    m_memory_arvalid,
  input  logic                    m_memory_arready,
  output logic [ADDR_WIDTH-1:0]   m_memory_araddr,
  output logic [LEN_WIDTH-1:0]    m_memory_arlen,
  output logic [ID_WIDTH-1:0]     m_memory_arid,
  output logic [2:0]              m_memory_arsize,
  output logic [1:0]              m_memory_arburst,
  output logic                    m_memory_arlock,
  output logic [3:0]              m_memory_arcache,
  output logic [2:0]              m_memory_arprot,
  output logic [3:0]              m_memory_arqos,

  input  logic                    m_memory_rvalid,
  output logic                    m_memory_rready,
  input  logic [DATA_WIDTH-1:0]   m_memory_rdata,
  input  logic                    m_memory_rlast,
  input  logic [1:0]              m_memory_rresp,
  input  logic [ID_WIDTH-1:0]     m_memory_rid
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int SIZE   = $clog2(BYTES);
  // Two spare bits let the read beat counter run one past len+1 so an
  // overrun is charged exactly once.
  localparam int BEAT_W = LEN_WIDTH + 2;

  axi_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [31:0]             seed_q, seed_d;
  logic [DELAY_WIDTH-1:0]  dly_q, dly_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    addr_error_q, addr_error_d;
  logic                    resp_error_q, resp_error_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;

  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic [31:0]             span_end;
  logic                    crosses_4k;
  logic [DATA_WIDTH-1:0]   pattern_data;
  logic [BEAT_W-1:0]       last_beat;
  logic                    rd_in_range;
  logic                    rd_mismatch;
  logic                    rd_overrun;
  logic                    rd_early_last;
  logic [1:0]              err_inc;
  logic [16:0]             err_sum;
  logic [15:0]             err_sat;
  logic                    unused_ok;

  axi_burst_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEAT_W     (BEAT_W)
  ) u_pattern (
    .seed (seed_q),
    .beat (beat_q),
    .data (pattern_data)
  );

  assign aligned_addr = base_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign span_end     = 32'(aligned_addr[11:0]) + (32'(burst_len) + 32'd1) * 32'(BYTES);
  assign crosses_4k   = span_end > 32'd4096;

  assign last_beat     = BEAT_W'(len_q);
  assign rd_in_range   = beat_q <= last_beat;
  assign rd_mismatch   = rd_in_range && (m_memory_rdata != pattern_data);
  assign rd_overrun    = beat_q == (last_beat + BEAT_W'(1));
  assign rd_early_last = m_memory_rlast && (beat_q < last_beat);
  assign err_inc       = {1'b0, rd_mismatch} + {1'b0, rd_overrun} + {1'b0, rd_early_last};
  assign err_sum       = {1'b0, err_cnt_q} + {15'b0, err_inc};
  assign err_sat       = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    seed_d       = seed_q;
    dly_d        = dly_q;
    beat_d       = beat_q;
    addr_error_d = addr_error_q;
    resp_error_d = resp_error_q;
    err_cnt_d    = err_cnt_q;
    read_data_d  = read_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start_write || start_read) begin
          addr_d       = aligned_addr;
          len_d        = burst_len;
          seed_d       = seed;
          dly_d        = cmd_delay;
          beat_d       = '0;
          addr_error_d = crosses_4k;
          resp_error_d = 1'b0;
          // A simultaneous start_write wins, so the read-side clear is skipped.
          if (!start_write) begin
            err_cnt_d = '0;
          end
          if (crosses_4k) begin
            state_d = ST_DONE;
          end else if (start_write) begin
            state_d = ST_AW;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AW: begin
        if (m_memory_awready) begin
          state_d = (dly_q == '0) ? ST_W : ST_WDLY;
        end
      end
      ST_WDLY: begin
        dly_d = dly_q - DELAY_WIDTH'(1);
        if (dly_q == DELAY_WIDTH'(1)) begin
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (m_memory_wready) begin
          if (beat_q == last_beat) begin
            beat_d  = '0;
            state_d = ST_B;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_B: begin
        if (m_memory_bvalid) begin
          if (m_memory_bresp != AXI_RESP_OKAY) begin
            resp_error_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_AR: begin
        if (m_memory_arready) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (m_memory_rvalid) begin
          err_cnt_d   = err_sat;
          read_data_d = m_memory_rdata;
          if (m_memory_rresp != AXI_RESP_OKAY) begin
            resp_error_d = 1'b1;
          end
          if (beat_q <= (last_beat + BEAT_W'(1))) begin
            beat_d = beat_q + BEAT_W'(1);
          end
          if (m_memory_rlast) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      seed_q       <= '0;
      dly_q        <= '0;
      beat_q       <= '0;
      addr_error_q <= 1'b0;
      resp_error_q <= 1'b0;
      err_cnt_q    <= '0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      seed_q       <= seed_d;
      dly_q        <= dly_d;
      beat_q       <= beat_d;
      addr_error_q <= addr_error_d;
      resp_error_q <= resp_error_d;
      err_cnt_q    <= err_cnt_d;
      read_data_q  <= read_data_d;
    end
  end

  // Valids and readies decode straight from the state register, so an
  // asynchronous reset drops them in the same instant.
  assign busy        = state_q != ST_IDLE;
  assign done        = state_q == ST_DONE;
  assign addr_error  = addr_error_q;
  assign resp_error  = resp_error_q;
  assign error_count = err_cnt_q;
  assign read_data   = read_data_q;

  assign m_memory_awvalid = state_q == ST_AW;
  assign m_memory_awaddr  = addr_q;
  assign m_memory_awlen   = len_q;
  assign m_memory_awid    = ID_WIDTH'(TX_ID);
  assign m_memory_awsize  = 3'(SIZE);
  assign m_memory_awburst = AXI_BURST_INCR;
  assign m_memory_awlock  = 1'b0;
  assign m_memory_awcache = 4'b0;
  assign m_memory_awprot  = 3'b0;
  assign m_memory_awqos   = 4'b0;

  assign m_memory_wvalid  = state_q == ST_W;
  assign m_memory_wdata   = pattern_data;
  assign m_memory_wstrb   = '1;
  assign m_memory_wlast   = beat_q == last_beat;
  assign m_memory_wid     = ID_WIDTH'(TX_ID);

  assign m_memory_bready  = state_q == ST_B;

  assign m_memory_arvalid = state_q == ST_AR;
  assign m_memory_araddr  = addr_q;
  assign m_memory_arlen   = len_q;
  assign m_memory_arid    = ID_WIDTH'(TX_ID);
  assign m_memory_arsize  = 3'(SIZE);
  assign m_memory_arburst = AXI_BURST_INCR;
  assign m_memory_arlock  = 1'b0;
  assign m_memory_arcache = 4'b0;
  assign m_memory_arprot  = 3'b0;
  assign m_memory_arqos   = 4'b0;

  assign m_memory_rready  = state_q == ST_R;

  assign unused_ok = ^{m_memory_bid, m_memory_rid};

endmodule

// File: tb/tb_axi_burst_tester.sv
// Directed bench for axi_burst_tester: an AXI memory slave plus a
// spec-level model of the pattern, burst shape and read error count.
module tb_axi_burst_tester;

  localparam int DW    = 64;
  localparam int BYTES = 8;
  localparam int LANES = 2;

  logic        clk;
  logic        rst_n;
  logic        start_write, start_read;
  logic [31:0] base_addr;
  logic [3:0]  burst_len;
  logic [31:0] seed_i;
  logic [7:0]  cmd_delay;
  logic        busy, done, addr_error, resp_error;
  logic [15:0] error_count;
  logic [63:0] read_data;

  logic        awvalid, awready, awlock, wvalid, wready, wlast;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen, awcache, awqos, arcache, arqos;
  logic [5:0]  awid, wid, bid, arid, rid;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready, arvalid, arready, arlock, rvalid, rready, rlast;

  axi_burst_tester dut (
    .clk(clk), .rst_n(rst_n), .start_write(start_write), .start_read(start_read),
    .base_addr(base_addr), .burst_len(burst_len), .seed(seed_i), .cmd_delay(cmd_delay),
    .busy(busy), .done(done), .addr_error(addr_error), .resp_error(resp_error),
    .error_count(error_count), .read_data(read_data),
    .m_memory_awvalid(awvalid), .m_memory_awready(awready), .m_memory_awaddr(awaddr),
    .m_memory_awlen(awlen), .m_memory_awid(awid), .m_memory_awsize(awsize),
    .m_memory_awburst(awburst), .m_memory_awlock(awlock), .m_memory_awcache(awcache),
    .m_memory_awprot(awprot), .m_memory_awqos(awqos),
    .m_memory_wvalid(wvalid), .m_memory_wready(wready), .m_memory_wdata(wdata),
    .m_memory_wstrb(wstrb), .m_memory_wlast(wlast), .m_memory_wid(wid),
    .m_memory_bvalid(bvalid), .m_memory_bready(bready), .m_memory_bresp(bresp), .m_memory_bid(bid),
    .m_memory_arvalid(arvalid), .m_memory_arready(arready), .m_memory_araddr(araddr),
    .m_memory_arlen(arlen), .m_memory_arid(arid), .m_memory_arsize(arsize),
    .m_memory_arburst(arburst), .m_memory_arlock(arlock), .m_memory_arcache(arcache),
    .m_memory_arprot(arprot), .m_memory_arqos(arqos),
    .m_memory_rvalid(rvalid), .m_memory_rready(rready), .m_memory_rdata(rdata),
    .m_memory_rlast(rlast), .m_memory_rresp(rresp), .m_memory_rid(rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- spec-level model ----------------
  logic [63:0] mem [int];

  function automatic logic [63:0] tb_pattern(input logic [31:0] s, input int beat);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[k*32 +: 32] = s + 32'(beat * LANES + k);
    return w;
  endfunction

  function automatic logic [63:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 64'h0;
  endfunction

  function automatic int exp_errors(input int a, input int len, input logic [31:0] s, input int sent);
    int e;
    int n;
    e = 0;
    n = (sent < len + 1) ? sent : len + 1;
    for (int i = 0; i < n; i++) if (mem_rd(a + i * BYTES) != tb_pattern(s, i)) e++;
    if (sent != len + 1) e++;
    return (e > 65535) ? 65535 : e;
  endfunction

  logic [31:0] m_addr = 0;
  int          m_len = 0;
  logic [31:0] m_seed = 0;
  int          m_delay = 0;
  int          aw_cnt = 0, ar_cnt = 0, done_cnt = 0, w_beats = 0, aw_cyc = 0, gap = -1;
  bit          first_w = 0;
  logic [63:0] first_wdata = 0;

  // ---------------- memory slave ----------------
  bit          cfg_stall = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_rresp = 2'b00;
  int          cfg_delta = 0;
  int          s_w_addr = 0, s_w_beat = 0, s_r_addr = 0, s_r_beat = 0, s_r_total = 0;

  initial begin : slave
    bit aw_f, w_f, b_f, ar_f, r_f, wl;
    logic [31:0] awa, ara;
    logic [3:0]  arl;
    logic [63:0] wd;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0;
    forever begin
      @(negedge clk);
      aw_f = awvalid && awready; awa = awaddr;
      w_f  = wvalid && wready;   wd = wdata; wl = wlast;
      b_f  = bvalid && bready;
      ar_f = arvalid && arready; ara = araddr; arl = arlen;
      r_f  = rvalid && rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
        continue;
      end
      if (aw_f) begin s_w_addr = int'(awa); s_w_beat = 0; end
      if (w_f) begin
        mem[s_w_addr + s_w_beat * BYTES] = wd;
        s_w_beat++;
        if (wl) begin bvalid = 1; bresp = cfg_bresp; end
      end
      if (b_f) bvalid = 0;
      if (ar_f) begin
        s_r_addr = int'(ara); s_r_total = int'(arl) + 1 + cfg_delta; s_r_beat = 0; rvalid = 1;
      end else if (r_f) begin
        s_r_beat++;
        if (s_r_beat >= s_r_total) rvalid = 0;
      end
      rdata   = rvalid ? mem_rd(s_r_addr + s_r_beat * BYTES) : 64'h0;
      rlast   = rvalid && (s_r_beat == s_r_total - 1);
      rresp   = rvalid ? cfg_rresp : 2'b00;
      awready = cfg_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      wready  = cfg_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      arready = cfg_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- per-cycle compare process ----------------
  initial begin : compare
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_done;
    logic [31:0] p_awaddr, p_araddr;
    logic [63:0] p_wdata;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_done = 0;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_outputs_low", 64'({awvalid, wvalid, arvalid, bready, rready, busy, done}), 64'h0);
        p_awv = 0; p_wv = 0; p_arv = 0; p_done = 0;
        continue;
      end
      if (p_awv && !p_awr) begin
        check("aw_hold_valid", 64'(awvalid), 64'h1);
        check("aw_hold_addr", 64'(awaddr), 64'(p_awaddr));
      end
      if (p_wv && !p_wr) begin
        check("w_hold_valid", 64'(wvalid), 64'h1);
        check("w_hold_data", wdata, p_wdata);
      end
      if (p_arv && !p_arr) check("ar_hold_valid", 64'(arvalid), 64'h1);
      if (awvalid) begin
        check("awaddr", 64'(awaddr), 64'(m_addr));
        check("awlen", 64'(awlen), 64'(m_len));
        check("aw_const", 64'({awsize, awburst, awlock, awcache, awprot, awqos, awid}),
              64'({3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 6'd0}));
        if (awready) begin aw_cnt++; aw_cyc = cyc; w_beats = 0; first_w = 1; end
      end
      if (wvalid) begin
        if (first_w) begin
          gap = cyc - aw_cyc - 1;
          check("wdly_gap", 64'(gap), 64'(m_delay));
          first_w = 0;
        end
        check("wdata", wdata, tb_pattern(m_seed, w_beats));
        check("wlast", 64'(wlast), 64'(w_beats == m_len));
        check("wstrb_wid", 64'({wstrb, wid}), 64'({8'hFF, 6'd0}));
        if (wready) begin
          if (w_beats == 0) first_wdata = wdata;
          w_beats++;
        end
      end
      if (arvalid) begin
        check("araddr", 64'(araddr), 64'(m_addr));
        check("arlen", 64'(arlen), 64'(m_len));
        check("ar_const", 64'({arsize, arburst, arlock, arcache, arprot, arqos, arid}),
              64'({3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 6'd0}));
        if (arready) ar_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_single_pulse", 64'(p_done), 64'h0);
      end
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_done = done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_op(input bit wr, input bit rd, input logic [31:0] a, input int len,
                          input logic [31:0] s, input int d);
    m_addr = a & ~32'(BYTES - 1); m_len = len; m_seed = s; m_delay = d;
    @(posedge clk); #1;
    base_addr = a; burst_len = len[3:0]; seed_i = s; cmd_delay = d[7:0];
    start_write = wr; start_read = rd;
    @(posedge clk); #1;
    start_write = 0; start_read = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'h0);
  endtask

  task automatic run_write(input logic [31:0] a, input int len, input logic [31:0] s, input int d);
    int lat;
    start_op(1, 0, a, len, s, d);
    wait_done(lat);
    check("write_beats", 64'(w_beats), 64'(len + 1));
  endtask

  task automatic run_read(input logic [31:0] a, input int len, input logic [31:0] s, input int delta);
    int lat;
    int sent;
    cfg_delta = delta;
    start_op(0, 1, a, len, s, 0);
    wait_done(lat);
    sent = len + 1 + delta;
    check("model_error_count", 64'(error_count), 64'(exp_errors(int'(m_addr), len, s, sent)));
    check("model_read_data", read_data, mem_rd(int'(m_addr) + (sent - 1) * BYTES));
    cfg_delta = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int lat, aw0, ar0, d0, seen;
    rst_n = 0; start_write = 0; start_read = 0;
    base_addr = 0; burst_len = 0; seed_i = 0; cmd_delay = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset_flags", 64'({busy, done, addr_error, resp_error}), 64'h0);
    check("reset_error_count", 64'(error_count), 64'h0);
    check("reset_read_data", read_data, 64'h0);

    // Pattern write with delay and random ready stalls
    cfg_stall = 1;
    run_write(32'h400, 3, 32'h01234567, 4);
    check("t1_aw_count", 64'(aw_cnt), 64'd1);
    check("t1_beat0", first_wdata, 64'h01234568_01234567);
    check("t1_gap", 64'(gap), 64'd4);
    check("t1_mem_beat3", mem_rd(32'h418), 64'h0123456E_0123456D);
    check("t1_done_count", 64'(done_cnt), 64'd1);

    // Read back, unaligned base ignored low bits
    cfg_stall = 0;
    run_read(32'h405, 3, 32'h01234567, 0);
    check("t2_error_count", 64'(error_count), 64'd0);
    check("t2_read_data", read_data, 64'h0123456E_0123456D);
    check("t2_resp_error", 64'(resp_error), 64'd0);
    check("t2_ar_count", 64'(ar_cnt), 64'd1);

    run_read(32'h400, 3, 32'hbabeface, 0);
    check("t3_error_count", 64'(error_count), 64'd4);

    // 4KB crossing rejected
    aw0 = aw_cnt;
    start_op(1, 0, 32'hFF0, 3, 32'h1, 0);
    wait_done(lat);
    check("t4_done_latency", 64'(lat), 64'd0);
    check("t4_addr_error", 64'(addr_error), 64'd1);
    check("t4_no_aw", 64'(aw_cnt), 64'(aw0));

    // Ends exactly at 4KB: legal, clears addr_error, zero delay
    run_write(32'hFE0, 3, 32'h11111111, 0);
    check("t5_addr_error_clear", 64'(addr_error), 64'd0);
    check("t5_gap", 64'(gap), 64'd0);

    cfg_bresp = 2'b10;
    run_write(32'h800, 1, 32'h55, 2);
    check("t6_resp_error_set", 64'(resp_error), 64'd1);
    cfg_bresp = 2'b00;
    run_write(32'h800, 1, 32'h55, 1);
    check("t6_resp_error_clear", 64'(resp_error), 64'd0);

    run_read(32'h400, 3, 32'h01234567, -2);
    check("t7_early_rlast", 64'(error_count), 64'd1);
    check("t7_read_data", read_data, 64'h0123456A_01234569);

    run_read(32'h400, 3, 32'h01234567, 2);
    check("t8_overrun", 64'(error_count), 64'd1);

    cfg_rresp = 2'b10;
    run_read(32'h400, 3, 32'hbabeface, 0);
    cfg_rresp = 2'b00;
    check("t9_rresp_error", 64'(resp_error), 64'd1);
    check("t9_error_count", 64'(error_count), 64'd4);

    // Simultaneous starts: write only, error_count untouched
    aw0 = aw_cnt; ar0 = ar_cnt;
    start_op(1, 1, 32'hC00, 2, 32'h777, 0);
    wait_done(lat);
    check("t10_aw_taken", 64'(aw_cnt), 64'(aw0 + 1));
    check("t10_ar_dropped", 64'(ar_cnt), 64'(ar0));
    check("t10_error_count_kept", 64'(error_count), 64'd4);
    check("t10_resp_error_clear", 64'(resp_error), 64'd0);

    // Reset while beat 2 is on the W channel
    start_op(1, 0, 32'h200, 3, 32'h9, 3);
    seen = 0; lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wvalid) begin
        if (seen == 2) begin lat = i; break; end
        if (wready) seen++;
      end
    end
    check("t11_reached_beat2", 64'(lat >= 0), 64'd1);
    #2 rst_n = 0;
    #1;
    check("t11_valids_low", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'h0);
    check("t11_busy_low", 64'(busy), 64'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    check("t11_read_data_reset", read_data, 64'h0);
    check("t11_error_count_reset", 64'(error_count), 64'h0);
    d0 = done_cnt;
    run_write(32'h200, 3, 32'h9, 3);
    check("t11_rewrite_beat3", mem_rd(32'h218), 64'h00000010_0000000F);
    check("t11_rewrite_done", 64'(done_cnt), 64'(d0 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
